// File: rtl/borrow_skip_subtractor.sv
// Iterative 8-bit subtractor: op1 - op2 - bin, one 2-bit group per clock,
// with borrow-skip across groups whose operand bits are equal.
module borrow_skip_subtractor (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] op1,
  input  logic [7:0] op2,
  input  logic       bin,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [8:0] diff,
  output logic [2:0] skip_cnt
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t     state_reg, state_next;
  logic [7:0] a_reg, b_reg;
  logic       bw_reg;
  logic [1:0] g_reg;
  logic [8:0] diff_reg;
  logic [2:0] skip_reg;

  logic [1:0] a_grp, b_grp, d_grp;
  logic       bw_mid, bw_ripple, grp_prop, bw_grp;

  // Current group slice and its ripple borrow chain
  always_comb begin
    a_grp     = a_reg[{g_reg, 1'b0} +: 2];
    b_grp     = b_reg[{g_reg, 1'b0} +: 2];
    d_grp[0]  = a_grp[0] ^ b_grp[0] ^ bw_reg;
    bw_mid    = (~a_grp[0] & b_grp[0]) | (~(a_grp[0] ^ b_grp[0]) & bw_reg);
    d_grp[1]  = a_grp[1] ^ b_grp[1] ^ bw_mid;
    bw_ripple = (~a_grp[1] & b_grp[1]) | (~(a_grp[1] ^ b_grp[1]) & bw_mid);
    grp_prop  = (a_grp ^ b_grp) == 2'b00;
    // Equal bits pass the incoming borrow straight through
    bw_grp    = grp_prop ? bw_reg : bw_ripple;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (in_valid)        state_next = RUN;
      RUN:     if (g_reg == 2'd3)   state_next = DONE;
      DONE:    if (out_ready)       state_next = IDLE;
      default:                      state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg    <= '0;
      b_reg    <= '0;
      bw_reg   <= 1'b0;
      g_reg    <= '0;
      diff_reg <= '0;
      skip_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            a_reg    <= op1;
            b_reg    <= op2;
            bw_reg   <= bin;
            g_reg    <= '0;
            diff_reg <= '0;
            skip_reg <= '0;
          end
        end
        RUN: begin
          diff_reg[{g_reg, 1'b0} +: 2] <= d_grp;
          bw_reg <= bw_grp;
          g_reg  <= g_reg + 2'd1;
          if (grp_prop) skip_reg <= skip_reg + 3'd1;
          if (g_reg == 2'd3) diff_reg[8] <= bw_grp;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign diff      = diff_reg;
  assign skip_cnt  = skip_reg;

endmodule

// File: tb/tb_borrow_skip_subtractor.sv
// Directed and randomized checks of borrow_skip_subtractor against a 9-bit
// arithmetic model, including backpressure, mid-run reset and throughput.
module tb_borrow_skip_subtractor;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] op1, op2;
  logic       bin;
  logic       out_valid;
  logic       out_ready;
  logic [8:0] diff;
  logic [2:0] skip_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  borrow_skip_subtractor dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .op1(op1), .op2(op2), .bin(bin),
    .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .skip_cnt(skip_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] ref_diff(input logic [7:0] a, input logic [7:0] b, input logic bi);
    logic [8:0] r;
    r = {1'b0, a} - {1'b0, b} - {8'd0, bi};
    return r;
  endfunction

  function automatic logic [2:0] ref_skip(input logic [7:0] a, input logic [7:0] b);
    logic [2:0] s;
    s = 3'd0;
    for (int k = 0; k < 4; k++)
      if (a[2*k +: 2] == b[2*k +: 2]) s = s + 3'd1;
    return s;
  endfunction

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin @(posedge clk); #1; n++; end
    if (!in_ready) check({tag, "_ready_timeout"}, in_ready, 1);
  endtask

  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic bi, input logic [8:0] ed, input logic [2:0] es);
    int n;
    wait_ready(tag);
    op1 = a; op2 = b; bin = bi; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    op1 = 8'($urandom); op2 = 8'($urandom); bin = 1'($urandom);
    n = 0;
    while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
    check({tag, "_latency"}, n, 4);
    check({tag, "_diff"}, diff, ed);
    check({tag, "_skip"}, skip_cnt, es);
    $display("op %s: %02h - %02h - %0d -> diff=%03h skip=%0d", tag, a, b, bi, diff, skip_cnt);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_drop"}, out_valid, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1);
  end

  initial begin
    int n;
    logic [8:0] held_diff;
    logic [7:0] a, b;
    logic       bi;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    op1 = '0; op2 = '0; bin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_diff", diff, 0);
    check("reset_skip", skip_cnt, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed vectors
    run_op("basic",    8'h5A, 8'h3C, 1'b0, 9'h01E, 3'd0);
    run_op("fullskip", 8'h55, 8'h55, 1'b1, 9'h1FF, 3'd4);
    run_op("ffff",     8'hFF, 8'hFF, 1'b0, 9'h000, 3'd4);
    run_op("mixed0",   8'h00, 8'h01, 1'b0, 9'h1FF, 3'd3);
    run_op("mixed1",   8'h80, 8'h01, 1'b1, 9'h07E, 3'd2);

    // Backpressure: DONE must hold while inputs churn
    wait_ready("bp");
    op1 = 8'h00; op2 = 8'h01; bin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
    check("bp_latency", n, 4);
    for (int i = 0; i < 10; i++) begin
      in_valid = ~in_valid;
      op1 = 8'($urandom); op2 = 8'($urandom); bin = 1'($urandom);
      @(posedge clk); #1;
      check("bp_out_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
      check("bp_diff", diff, 9'h1FF);
      check("bp_skip", skip_cnt, 3);
      $display("bp cycle %0d: out_valid=%0d in_ready=%0d diff=%03h skip=%0d",
               i, out_valid, in_ready, diff, skip_cnt);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_release_valid", out_valid, 0);
    check("bp_release_ready", in_ready, 1);

    // Reset during the second RUN cycle
    wait_ready("rstmid");
    op1 = 8'h5A; op2 = 8'h3C; bin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    held_diff = diff;
    check("rstmid_partial", held_diff, 9'h002);
    rst = 1'b1;
    #1;
    check("rstmid_out_valid", out_valid, 0);
    check("rstmid_in_ready", in_ready, 1);
    check("rstmid_diff", diff, 0);
    check("rstmid_skip", skip_cnt, 0);
    $display("rstmid: out_valid=%0d in_ready=%0d diff=%03h skip=%0d", out_valid, in_ready, diff, skip_cnt);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      check("rstmid_no_result", out_valid, 0);
    end
    run_op("after_rst", 8'h10, 8'h01, 1'b0, 9'h00F, 3'd2);

    // Throughput with in_valid and out_ready tied high
    in_valid = 1'b1; out_ready = 1'b1;
    wait_ready("tp");
    for (int i = 0; i < 40; i++) begin
      case (i)
        0: begin a = 8'h00; b = 8'h00; bi = 1'b0; end
        1: begin a = 8'h00; b = 8'h00; bi = 1'b1; end
        2: begin a = 8'hFF; b = 8'h00; bi = 1'b1; end
        3: begin a = 8'h00; b = 8'hFF; bi = 1'b1; end
        4: begin a = 8'hAA; b = 8'h55; bi = 1'b0; end
        default: begin a = 8'($urandom); b = 8'($urandom); bi = 1'($urandom); end
      endcase
      op1 = a; op2 = b; bin = bi;
      @(posedge clk); #1;
      n = 0;
      while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
      check("tp_latency", n, 4);
      check("tp_diff", diff, ref_diff(a, b, bi));
      check("tp_skip", skip_cnt, ref_skip(a, b));
      $display("tp %0d: %02h - %02h - %0d -> diff=%03h skip=%0d", i, a, b, bi, diff, skip_cnt);
      while (!in_ready && n < 20) begin @(posedge clk); #1; n++; end
      check("tp_interval", n, 5);
    end
    in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/borrow_skip_subtractor.md
# borrow_skip_subtractor

Iterative 8-bit subtractor computing op1 − op2 − bin, two bits per clock with borrow-skip across 2-bit groups. It is the inverse arithmetic companion of the datapath carry-skip adder and sits beside it in the arithmetic unit. It takes operands through a valid/ready input handshake and returns a 9-bit result through a valid/ready output handshake. It also reports how many groups the borrow skipped, which exposes the skip path to verification.

## Interface
Parameters: none (width fixed at 8, group size fixed at 2).

Ports (clock and reset first):
- clk  input  1  single clock; all state changes on its rising edge
- rst  input  1  reset, asynchronous, active-high
- in_valid  input  1  operands valid
- in_ready  output  1  block can accept operands; high only in IDLE
- op1  input  8  minuend
- op2  input  8  subtrahend
- bin  input  1  borrow in
- out_valid  output  1  result valid; high only in DONE
- out_ready  input  1  consumer accepts result
- diff  output  9  {bout, d[7:0]} = (op1 − op2 − bin) mod 512; diff[8]=1 iff op1 < op2 + bin
- skip_cnt  output  3  number of groups (0..4) whose borrow was skipped

## Operation
- State machine with three states:
  - IDLE: in_ready=1. On in_valid&&in_ready, register op1, op2 and bin into the operand registers. Clear the running result, set group index g=0 and skip_cnt=0, then go to RUN.
  - RUN: one group per cycle, g = 0..3, covering bits [2g+1:2g]. The bit difference is d = a ^ b ^ bw_in and the bit borrow is bw_out = (~a & b) | (~(a ^ b) & bw_in).
    - Group propagate P = (a^b)==0 for both bits.
    - If P, group borrow-out = group borrow-in (skip path) and skip_cnt increments.
    - Otherwise group borrow-out comes from the ripple.
    - Both paths must give identical arithmetic results.
    - After g=3, diff[8] = final borrow and the state goes to DONE.
  - DONE: out_valid=1. diff and skip_cnt are held stable. On out_ready go to IDLE.
- Inputs and in_valid are ignored outside IDLE. Operand changes after capture do not affect the result.
- diff and skip_cnt keep their last values in IDLE until the next capture. Only out_valid qualifies them.
- No same-cycle result-out/operand-in overlap: DONE→IDLE takes one edge, and the next accept is in IDLE.

## Timing
- Reset (async assert, any state): state=IDLE, in_ready=1, out_valid=0, diff=0, skip_cnt=0, operand registers=0, g=0.
- Reset mid-RUN or mid-DONE aborts the operation. No result is produced.
- Release takes effect on the first rising edge with rst low.
- For an accept at edge T:
  - Groups 0..3 are processed at edges T+1..T+4.
  - DONE is entered at edge T+4, so out_valid is high from T+4.
  - Latency from accept to out_valid is 4 cycles.
- With out_ready tied high, DONE lasts 1 cycle and IDLE is re-entered at edge T+5. The next accept is no earlier than T+5, giving 5 cycles per operation at best.
- With out_ready low, DONE holds indefinitely. out_valid, diff and skip_cnt stay constant and in_ready stays 0.
- in_ready and out_valid are decoded from registered state only, with no combinational path from inputs.

## Test plan
- Basic: op1=0x5A, op2=0x3C, bin=0 → diff=0x01E, skip_cnt=0. out_valid rises exactly 4 cycles after the accept edge.
- Full skip with underflow: op1=0x55, op2=0x55, bin=1 → diff=0x1FF, skip_cnt=4. Also 0xFF−0xFF−0 → diff=0x000, skip_cnt=4.
- Mixed skip: op1=0x00, op2=0x01, bin=0 → diff=0x1FF, skip_cnt=3. Also op1=0x80, op2=0x01, bin=1 → diff=0x07E.
- Backpressure: hold out_ready=0 for 10 cycles in DONE while toggling in_valid and operands.
  - diff, skip_cnt and out_valid=1 stay stable and in_ready stays 0.
  - Raising out_ready gives out_valid=0 at the next edge.
- Reset mid-operation: assert rst during the 2nd RUN cycle.
  - Immediately (asynchronously) out_valid=0, in_ready=1, diff=0 and skip_cnt=0.
  - A following 0x10−0x01−0 returns 0x00F.
- Throughput and exhaustive: with in_valid and out_ready tied high, accepts occur every 5 cycles. Random and exhaustive op1/op2/bin results match the 9-bit reference model, and skip_cnt matches the count of groups with equal operand bits.
